// File: rtl/adder_pipe_hs.sv
// adder_pipe_hs: multi-lane signed add/subtract pipeline with valid/ready
// handshaking at both ports.
//
// Each lane computes a + b (or a - b when sub_i=1) at DATAW+1 bits and
// registers the DATAW-bit result plus an overflow flag into stage 0. Later
// stages only carry data. The pipeline is elastic: a stage advances when it
// is empty or when the stage after it advances, so backpressure from
// ready_i stalls the pipe without dropping or duplicating transactions.
//
// Optional build macro ADDER_SAT_EN:
//   defined   -> overflowing lanes saturate to the signed min/max value
//   undefined -> overflowing lanes wrap (two's complement low DATAW bits)
// ovf_o flags the affected lanes in both builds.
module adder_pipe_hs #(
  parameter int DATAW = 16,
  parameter int LANES = 4,
  parameter int PIPES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   sub_i,
  input  logic [LANES*DATAW-1:0] dataa_i,
  input  logic [LANES*DATAW-1:0] datab_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [LANES*DATAW-1:0] sum_o,
  output logic [LANES-1:0]       ovf_o,
  output logic [31:0]            count_o
);

  localparam int VW = LANES * DATAW;

  // One lane of arithmetic. Returns {overflow, result[DATAW-1:0]}.
  // Operands are sign-extended by one bit so the true result always fits;
  // overflow is a disagreement between the two top bits of that result.
  function automatic logic [DATAW:0] lane_op(
    input logic [DATAW-1:0] a,
    input logic [DATAW-1:0] b,
    input logic             sub
  );
    logic [DATAW:0]   ax;
    logic [DATAW:0]   bx;
    logic [DATAW:0]   r;
    logic             ovf;
    logic [DATAW-1:0] res;
    ax = {a[DATAW-1], a};
    bx = {b[DATAW-1], b};
    if (sub) begin
      r = ax - bx;
    end else begin
      r = ax + bx;
    end
    ovf = r[DATAW] ^ r[DATAW-1];
`ifdef ADDER_SAT_EN
    if (ovf) begin
      if (r[DATAW]) begin
        res = {1'b1, {(DATAW-1){1'b0}}};
      end else begin
        res = {1'b0, {(DATAW-1){1'b1}}};
      end
    end else begin
      res = r[DATAW-1:0];
    end
`else
    res = r[DATAW-1:0];
`endif
    return {ovf, res};
  endfunction

  logic [PIPES-1:0] v_q;
  logic [PIPES-1:0] v_d;
  logic [PIPES-1:0] adv_s;
  logic [VW-1:0]    sum_q [PIPES];
  logic [VW-1:0]    sum_d [PIPES];
  logic [LANES-1:0] ovf_q [PIPES];
  logic [LANES-1:0] ovf_d [PIPES];
  logic [31:0]      count_q;
  logic [31:0]      count_d;
  logic [VW-1:0]    in_sum_s;
  logic [LANES-1:0] in_ovf_s;

  // Per-lane arithmetic on the input operands; lanes never share carries.
  always_comb begin
    logic [DATAW:0] lane_r;
    in_sum_s = '0;
    in_ovf_s = '0;
    lane_r   = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_r = lane_op(dataa_i[k*DATAW +: DATAW], datab_i[k*DATAW +: DATAW], sub_i);
      in_sum_s[k*DATAW +: DATAW] = lane_r[DATAW-1:0];
      in_ovf_s[k]                = lane_r[DATAW];
    end
  end

  // Advance chain: stage s moves when any stage from s to the output is
  // empty or the consumer takes the output, written as a running OR so the
  // chain has no self-referencing vector.
  always_comb begin
    logic acc;
    acc   = ready_i;
    adv_s = '0;
    for (int s = PIPES - 1; s >= 0; s--) begin
      acc      = acc | ~v_q[s];
      adv_s[s] = acc;
    end
  end

  // Next-state for stage valid bits, stage data and the transfer counter.
  always_comb begin
    v_d     = v_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    if (adv_s[0]) begin
      v_d[0]   = valid_i;
      sum_d[0] = in_sum_s;
      ovf_d[0] = in_ovf_s;
    end else begin
      v_d[0]   = v_q[0];
    end
    for (int s = 1; s < PIPES; s++) begin
      if (adv_s[s]) begin
        v_d[s]   = v_q[s-1];
        sum_d[s] = sum_q[s-1];
        ovf_d[s] = ovf_q[s-1];
      end else begin
        v_d[s]   = v_q[s];
      end
    end
    if (v_q[PIPES-1] && ready_i) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Pipeline registers with synchronous reset that flushes every stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q     <= '0;
      count_q <= 32'd0;
      for (int s = 0; s < PIPES; s++) begin
        sum_q[s] <= '0;
        ovf_q[s] <= '0;
      end
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int s = 0; s < PIPES; s++) begin
        sum_q[s] <= sum_d[s];
        ovf_q[s] <= ovf_d[s];
      end
    end
  end

  assign ready_o = adv_s[0];
  assign valid_o = v_q[PIPES-1];
  assign sum_o   = sum_q[PIPES-1];
  assign ovf_o   = ovf_q[PIPES-1];
  assign count_o = count_q;

endmodule
